// File: rtl/maquina_pkg.sv
// Shared constants for the vending transaction controller: state
// encodings, default datapath width and slot address width.
package maquina_pkg;

  localparam int CW_DEF = 8;
  localparam int ADDR_W = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOOKUP   = 3'd1;
  localparam logic [2:0] ST_COLLECT  = 3'd2;
  localparam logic [2:0] ST_DISPENSE = 3'd3;
  localparam logic [2:0] ST_CHANGE   = 3'd4;
  localparam logic [2:0] ST_REFUND   = 3'd5;
  localparam logic [2:0] ST_FAULT    = 3'd6;

endpackage

// File: rtl/contador_timeout.sv
// Cycle counter with synchronous load-to-zero and a terminal-count flag.
// o_tc is raised on the N-th consecutive enabled cycle after a load, so a
// caller that acts on o_tc spends exactly N cycles waiting.
module contador_timeout #(
  parameter int N = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_enable,
  output logic o_tc
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_count;

  // Count enabled cycles since the last load, holding at the last value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = i_enable && !i_load && (r_count == LAST);

endmodule

// File: rtl/controle_venda.sv
// Vending transaction sequencer: takes the latched keypad selection, looks
// up its price, collects coin credit, runs the dispense motor and returns
// change or a refund, then pulses ok to release the keypad controller.
module controle_venda
  import maquina_pkg::*;
#(
  parameter int CW          = CW_DEF,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MOTOR_CYC   = 500
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sel_valid,
  input  logic [1:0]          i_sel_linha,
  input  logic [1:0]          i_sel_coluna,
  input  logic                i_coin_valid,
  input  logic [CW-1:0]       i_coin_value,
  input  logic                i_cancel,
  input  logic                i_motor_done,
  output logic [ADDR_W-1:0]   o_price_addr,
  input  logic [CW-1:0]       i_price_data,
  output logic                o_motor_en,
  output logic [ADDR_W-1:0]   o_motor_addr,
  output logic                o_change_valid,
  output logic [CW-1:0]       o_change_amount,
  output logic [CW-1:0]       o_credit,
  output logic                o_ok,
  output logic                o_coin_reject,
  output logic                o_fault,
  output logic                o_busy
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_price_addr;
  logic [ADDR_W-1:0] r_motor_addr;
  logic [CW-1:0]     r_price;
  logic [CW-1:0]     r_credit;
  logic [CW-1:0]     r_change_amount;
  logic              r_change_valid;
  logic              r_motor_en;
  logic              r_ok;
  logic              r_coin_reject;
  logic              r_fault;
  logic              r_busy;

  logic [2:0]        w_state_nxt;
  logic [CW:0]       w_coin_sum;
  logic [CW:0]       w_fault_sum;
  logic [CW-1:0]     w_fault_amt;
  logic [CW-1:0]     w_credit_acc;
  logic              w_coin_state;
  logic              w_coin_ok;
  logic              w_collect_tc;
  logic              w_motor_tc;

  // A coin is taken only if it fits without clipping; otherwise the whole
  // coin goes back and credit is left alone.
  assign w_coin_state = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign w_coin_sum   = {1'b0, r_credit} + {1'b0, i_coin_value};
  assign w_coin_ok    = i_coin_valid && w_coin_state && !w_coin_sum[CW];
  assign w_credit_acc = w_coin_ok ? w_coin_sum[CW-1:0] : r_credit;

  // On a motor fault the customer is owed what was left plus what was charged.
  assign w_fault_sum  = {1'b0, r_credit} + {1'b0, r_price};
  assign w_fault_amt  = w_fault_sum[CW] ? {CW{1'b1}} : w_fault_sum[CW-1:0];

  // Inactivity timer: cleared outside COLLECT and by every accepted coin.
  contador_timeout #(.N(TIMEOUT_CYC)) u_collect_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   ((r_state != ST_COLLECT) || w_coin_ok),
    .i_enable (r_state == ST_COLLECT),
    .o_tc     (w_collect_tc)
  );

  // Motor watchdog: runs only while the motor is being driven.
  contador_timeout #(.N(MOTOR_CYC)) u_motor_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (r_state != ST_DISPENSE),
    .i_enable (r_state == ST_DISPENSE),
    .o_tc     (w_motor_tc)
  );

  // Transaction state sequencing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_sel_valid)                         w_state_nxt = ST_LOOKUP;
        else if (i_cancel && (r_credit != '0))   w_state_nxt = ST_REFUND;
      end
      ST_LOOKUP:   w_state_nxt = ST_COLLECT;
      ST_COLLECT: begin
        if (i_cancel)                            w_state_nxt = ST_REFUND;
        else if (r_credit >= r_price)            w_state_nxt = ST_DISPENSE;
        else if (w_collect_tc)                   w_state_nxt = ST_REFUND;
      end
      ST_DISPENSE: begin
        if (i_motor_done)                        w_state_nxt = ST_CHANGE;
        else if (w_motor_tc)                     w_state_nxt = ST_FAULT;
      end
      ST_CHANGE:   w_state_nxt = ST_IDLE;
      ST_REFUND:   w_state_nxt = ST_IDLE;
      ST_FAULT:    w_state_nxt = ST_FAULT;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered datapath and outputs, updated on each state transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_price_addr    <= '0;
      r_motor_addr    <= '0;
      r_price         <= '0;
      r_credit        <= '0;
      r_change_amount <= '0;
      r_change_valid  <= 1'b0;
      r_motor_en      <= 1'b0;
      r_ok            <= 1'b0;
      r_coin_reject   <= 1'b0;
      r_fault         <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_ok           <= 1'b0;
      r_change_valid <= 1'b0;
      r_coin_reject  <= i_coin_valid && !w_coin_ok;
      r_credit       <= w_credit_acc;

      if ((r_state == ST_IDLE) && i_sel_valid) begin
        r_addr       <= {i_sel_linha, i_sel_coluna};
        r_price_addr <= {i_sel_linha, i_sel_coluna};
      end

      if (r_state == ST_LOOKUP) begin
        r_price <= i_price_data;
      end

      if ((r_state == ST_COLLECT) && (w_state_nxt == ST_DISPENSE)) begin
        r_credit     <= w_credit_acc - r_price;
        r_motor_en   <= 1'b1;
        r_motor_addr <= r_addr;
      end

      if (w_state_nxt == ST_CHANGE) begin
        r_motor_en      <= 1'b0;
        r_ok            <= 1'b1;
        r_change_valid  <= (r_credit != '0);
        r_change_amount <= r_credit;
        r_credit        <= '0;
      end

      if (w_state_nxt == ST_REFUND) begin
        r_ok            <= 1'b1;
        r_change_valid  <= (w_credit_acc != '0);
        r_change_amount <= w_credit_acc;
        r_credit        <= '0;
      end

      if ((r_state == ST_DISPENSE) && (w_state_nxt == ST_FAULT)) begin
        r_motor_en      <= 1'b0;
        r_fault         <= 1'b1;
        r_change_valid  <= 1'b1;
        r_change_amount <= w_fault_amt;
        r_credit        <= '0;
      end
    end
  end

  assign o_price_addr    = r_price_addr;
  assign o_motor_en      = r_motor_en;
  assign o_motor_addr    = r_motor_addr;
  assign o_change_valid  = r_change_valid;
  assign o_change_amount = r_change_amount;
  assign o_credit        = r_credit;
  assign o_ok            = r_ok;
  assign o_coin_reject   = r_coin_reject;
  assign o_fault         = r_fault;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_controle_venda.sv
// Directed bench for controle_venda: expected transaction closes (change,
// refund, fault) are queued as stimulus is driven and checked when the
// DUT raises ok or change_valid.
module tb_controle_venda;

  logic       clk = 1'b0;
  logic       rstN;
  logic       selValid;
  logic [1:0] selLinha;
  logic [1:0] selColuna;
  logic       coinValid;
  logic [7:0] coinValue;
  logic       cancel;
  logic       motorDone;
  logic [3:0] priceAddr;
  logic [7:0] romData;
  logic       motorEn;
  logic [3:0] motorAddr;
  logic       changeValid;
  logic [7:0] changeAmount;
  logic [7:0] credit;
  logic       ok;
  logic       coinReject;
  logic       fault;
  logic       busy;

  typedef struct {
    logic       hasChange;
    logic [7:0] amount;
    logic       expOk;
  } closeT;

  closeT expQ[$];
  int testsRun  = 0;
  int failCount = 0;
  int waited;
  int hiCount;

  controle_venda dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_sel_valid     (selValid),
    .i_sel_linha     (selLinha),
    .i_sel_coluna    (selColuna),
    .i_coin_valid    (coinValid),
    .i_coin_value    (coinValue),
    .i_cancel        (cancel),
    .i_motor_done    (motorDone),
    .o_price_addr    (priceAddr),
    .i_price_data    (romData),
    .o_motor_en      (motorEn),
    .o_motor_addr    (motorAddr),
    .o_change_valid  (changeValid),
    .o_change_amount (changeAmount),
    .o_credit        (credit),
    .o_ok            (ok),
    .o_coin_reject   (coinReject),
    .o_fault         (fault),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  // Price ROM contents: slot 5 costs 150, slot 0 is free.
  always_comb begin
    case (priceAddr)
      4'd5:    romData = 8'd150;
      4'd0:    romData = 8'd0;
      default: romData = 8'd77;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] l, input logic [1:0] c,
                               input logic coin, input logic [7:0] v, input logic cnc);
    selValid  = sel;
    selLinha  = l;
    selColuna = c;
    coinValid = coin;
    coinValue = v;
    cancel    = cnc;
    @(negedge clk);
    selValid  = 1'b0;
    coinValid = 1'b0;
    coinValue = 8'd0;
    cancel    = 1'b0;
  endtask

  task automatic pushClose(input logic hasChange, input logic [7:0] amount, input logic expOk);
    closeT e;
    e.hasChange = hasChange;
    e.amount    = amount;
    e.expOk     = expOk;
    expQ.push_back(e);
  endtask

  task automatic waitEvent(input string tag, input int maxCycles, output int cycles);
    cycles = 0;
    while (!(ok === 1'b1 || changeValid === 1'b1) && cycles < maxCycles) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_seen"}, {31'd0, (ok | changeValid)}, 32'd1);
  endtask

  task automatic checkClose(input string tag);
    closeT e;
    checkOutput({tag, "_pending"}, {31'd0, (expQ.size() > 0)}, 32'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({tag, "_change_valid"}, {31'd0, changeValid}, {31'd0, e.hasChange});
      if (e.hasChange) checkOutput({tag, "_change_amount"}, {24'd0, changeAmount}, {24'd0, e.amount});
      checkOutput({tag, "_ok"}, {31'd0, ok}, {31'd0, e.expOk});
    end
  endtask

  initial begin
    rstN = 1'b0; selValid = 1'b0; selLinha = 2'd0; selColuna = 2'd0;
    coinValid = 1'b0; coinValue = 8'd0; cancel = 1'b0; motorDone = 1'b0;
    tick(2);
    checkOutput("reset_credit", {24'd0, credit}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_motor_en", {31'd0, motorEn}, 32'd0);
    checkOutput("reset_fault", {31'd0, fault}, 32'd0);
    checkOutput("reset_change_valid", {31'd0, changeValid}, 32'd0);
    checkOutput("reset_ok", {31'd0, ok}, 32'd0);
    rstN = 1'b1;
    tick(1);

    // Purchase with change: 100 + 100 against price 150.
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 8'd0, 1'b0);
    checkOutput("buy_price_addr", {28'd0, priceAddr}, 32'd5);
    checkOutput("buy_busy", {31'd0, busy}, 32'd1);
    tick(1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd100, 1'b0);
    checkOutput("buy_credit_100", {24'd0, credit}, 32'd100);
    checkOutput("buy_no_reject", {31'd0, coinReject}, 32'd0);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd100, 1'b0);
    checkOutput("buy_credit_200", {24'd0, credit}, 32'd200);
    tick(1);
    checkOutput("buy_motor_en", {31'd0, motorEn}, 32'd1);
    checkOutput("buy_credit_after_price", {24'd0, credit}, 32'd50);
    checkOutput("buy_motor_addr", {28'd0, motorAddr}, 32'd5);
    tick(3);
    checkOutput("buy_motor_held", {31'd0, motorEn}, 32'd1);
    pushClose(1'b1, 8'd50, 1'b1);
    motorDone = 1'b1;
    tick(1);
    motorDone = 1'b0;
    waitEvent("buy", 5, waited);
    checkClose("buy");
    checkOutput("buy_motor_off", {31'd0, motorEn}, 32'd0);
    tick(1);
    checkOutput("buy_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("buy_idle_credit", {24'd0, credit}, 32'd0);

    // Cancel with a coin arriving in the same cycle: refund includes it.
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 8'd0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd100, 1'b0);
    checkOutput("cancel_credit", {24'd0, credit}, 32'd100);
    pushClose(1'b1, 8'd120, 1'b1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd20, 1'b1);
    waitEvent("cancel", 5, waited);
    checkClose("cancel");
    checkOutput("cancel_no_motor", {31'd0, motorEn}, 32'd0);
    tick(1);
    checkOutput("cancel_idle", {31'd0, busy}, 32'd0);

    // Inactivity timeout refunds exactly 1000 cycles after the last coin.
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 8'd0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd100, 1'b0);
    tick(990);
    checkOutput("timeout_still_busy", {31'd0, busy}, 32'd1);
    checkOutput("timeout_still_credit", {24'd0, credit}, 32'd100);
    checkOutput("timeout_not_early", {31'd0, changeValid}, 32'd0);
    pushClose(1'b1, 8'd100, 1'b1);
    waitEvent("timeout", 50, waited);
    checkOutput("timeout_cycles", waited, 32'd10);
    checkClose("timeout");
    tick(1);

    // Saturation: a coin that would overflow is rejected whole.
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd200, 1'b0);
    checkOutput("sat_credit_200", {24'd0, credit}, 32'd200);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd100, 1'b0);
    checkOutput("sat_reject_100", {31'd0, coinReject}, 32'd1);
    checkOutput("sat_credit_kept", {24'd0, credit}, 32'd200);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd55, 1'b0);
    checkOutput("sat_exact_fit", {24'd0, credit}, 32'd255);
    checkOutput("sat_exact_no_reject", {31'd0, coinReject}, 32'd0);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd1, 1'b0);
    checkOutput("sat_reject_1", {31'd0, coinReject}, 32'd1);
    tick(1);
    checkOutput("sat_reject_pulse_end", {31'd0, coinReject}, 32'd0);

    // Coin during DISPENSE is rejected; async reset then kills the transaction.
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 8'd0, 1'b0);
    tick(2);
    checkOutput("disp_motor_en", {31'd0, motorEn}, 32'd1);
    checkOutput("disp_credit_105", {24'd0, credit}, 32'd105);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd10, 1'b0);
    checkOutput("disp_coin_reject", {31'd0, coinReject}, 32'd1);
    checkOutput("disp_credit_unchanged", {24'd0, credit}, 32'd105);
    #2 rstN = 1'b0;
    #1;
    checkOutput("areset_motor_en", {31'd0, motorEn}, 32'd0);
    checkOutput("areset_credit", {24'd0, credit}, 32'd0);
    checkOutput("areset_busy", {31'd0, busy}, 32'd0);
    checkOutput("areset_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    tick(2);
    checkOutput("areset_no_refund", {31'd0, (changeValid | ok)}, 32'd0);

    // Free slot dispenses at once; withheld motor_done drives FAULT.
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 8'd0, 1'b0);
    checkOutput("free_busy", {31'd0, busy}, 32'd1);
    tick(2);
    checkOutput("free_motor_en", {31'd0, motorEn}, 32'd1);
    checkOutput("free_motor_addr", {28'd0, motorAddr}, 32'd0);
    hiCount = 0;
    while (motorEn === 1'b1 && hiCount < 600) begin
      hiCount++;
      @(negedge clk);
    end
    checkOutput("fault_motor_cycles", hiCount, 32'd500);
    pushClose(1'b1, 8'd0, 1'b0);
    checkClose("fault");
    checkOutput("fault_flag", {31'd0, fault}, 32'd1);
    checkOutput("fault_busy", {31'd0, busy}, 32'd1);
    tick(20);
    checkOutput("fault_sticky", {31'd0, fault}, 32'd1);
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 8'd0, 1'b0);
    tick(3);
    checkOutput("fault_sel_ignored_addr", {28'd0, priceAddr}, 32'd0);
    checkOutput("fault_sel_ignored_motor", {31'd0, motorEn}, 32'd0);
    checkOutput("fault_no_ok", {31'd0, ok}, 32'd0);
    checkOutput("fault_still", {31'd0, fault}, 32'd1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'd5, 1'b0);
    checkOutput("fault_coin_reject", {31'd0, coinReject}, 32'd1);
    checkOutput("fault_credit_zero", {24'd0, credit}, 32'd0);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
